// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
// Forwarding selects, load-use stalls and branch flushes for a 5-stage RISC-V
// pipeline. The MEM/WB destination tags are shadowed locally so that the EX
// operand selection depends only on registered state plus the EX indices.
// A small RUN/STALL/FLUSH FSM masks the EX inputs for the cycle after a stall
// or flush, when EX holds a bubble or a squashed instruction.
// Optional feature macro: HAZARD_PERF_EN (saturating stall/flush counters).

module hazard_forward_unit #(
    parameter int REG_W = 5
`ifdef HAZARD_PERF_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] RS1_ID,
    input  logic [REG_W-1:0] RS2_ID,
    input  logic [REG_W-1:0] RS1_EX,
    input  logic [REG_W-1:0] RS2_EX,
    input  logic [REG_W-1:0] RD_EX,
    input  logic             RegWrite_EX,
    input  logic             MemRead_EX,
    input  logic             PCSrc_MEM,
    output logic [1:0]       forwardA,
    output logic [1:0]       forwardB,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             ID_EX_bubble,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             EX_MEM_flush,
    output logic [REG_W-1:0] RD_MEM_TAG,
    output logic [REG_W-1:0] RD_WB_TAG
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};

    state_t           state_r;
    state_t           state_nxt_s;
    logic             mem_vld_r;
    logic [REG_W-1:0] mem_rd_r;
    logic             wb_vld_r;
    logic [REG_W-1:0] wb_rd_r;
    logic             run_s;
    logic             lu_s;
    logic             mem_vld_nxt_s;

    // A valid shadow tag naming the same register as the EX source operand.
    function automatic logic tag_hit(input logic             vld,
                                     input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] rs);
        return vld && (rd == rs);
    endfunction

    assign run_s = (state_r == ST_RUN);

    // Load-use hazard: the load in EX targets a source of the ID instruction.
    // Not evaluated outside RUN because EX then holds a bubble.
    assign lu_s = MemRead_EX && (RD_EX != REG_ZERO) &&
                  ((RD_EX == RS1_ID) || (RD_EX == RS2_ID)) && run_s;

    // A writer only becomes a forwarding source if it is real (RUN), targets
    // a non-zero register and is not being squashed by a taken branch.
    assign mem_vld_nxt_s = RegWrite_EX && (RD_EX != REG_ZERO) && run_s && !PCSrc_MEM;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: a flush always wins; stall and flush last one cycle.
    always_comb begin
        state_nxt_s = ST_RUN;
        case (state_r)
            ST_RUN: begin
                if (PCSrc_MEM) begin
                    state_nxt_s = ST_FLUSH;
                end else if (lu_s) begin
                    state_nxt_s = ST_STALL;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_STALL, ST_FLUSH: begin
                if (PCSrc_MEM) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // Shadow MEM/WB destination tags; rd is kept zero while the tag is invalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_vld_r <= 1'b0;
            mem_rd_r  <= REG_ZERO;
            wb_vld_r  <= 1'b0;
            wb_rd_r   <= REG_ZERO;
        end else begin
            wb_vld_r  <= mem_vld_r;
            wb_rd_r   <= mem_rd_r;
            mem_vld_r <= mem_vld_nxt_s;
            mem_rd_r  <= mem_vld_nxt_s ? RD_EX : REG_ZERO;
        end
    end

    assign RD_MEM_TAG = mem_vld_r ? mem_rd_r : REG_ZERO;
    assign RD_WB_TAG  = wb_vld_r  ? wb_rd_r  : REG_ZERO;

    // Operand selects: MEM result beats WB data; masked outside RUN.
    always_comb begin
        forwardA = 2'b00;
        forwardB = 2'b00;
        if (!run_s) begin
            forwardA = 2'b00;
            forwardB = 2'b00;
        end else begin
            if (tag_hit(mem_vld_r, mem_rd_r, RS1_EX)) begin
                forwardA = 2'b10;
            end else if (tag_hit(wb_vld_r, wb_rd_r, RS1_EX)) begin
                forwardA = 2'b01;
            end else begin
                forwardA = 2'b00;
            end
            if (tag_hit(mem_vld_r, mem_rd_r, RS2_EX)) begin
                forwardB = 2'b10;
            end else if (tag_hit(wb_vld_r, wb_rd_r, RS2_EX)) begin
                forwardB = 2'b01;
            end else begin
                forwardB = 2'b00;
            end
        end
    end

    // Pipeline enables, bubble and flushes; reset forces the idle values
    // immediately so downstream registers see them without a clock edge.
    always_comb begin
        PC_write     = 1'b1;
        IF_ID_write  = 1'b1;
        ID_EX_bubble = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_flush = 1'b0;
        if (reset) begin
            PC_write     = 1'b1;
            IF_ID_write  = 1'b1;
        end else if (PCSrc_MEM) begin
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            EX_MEM_flush = 1'b1;
        end else if (lu_s) begin
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
        end else begin
            PC_write     = 1'b1;
            IF_ID_write  = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // Saturating event counters for stall cycles and flush cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (lu_s && !PCSrc_MEM && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (PCSrc_MEM && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// behavioural model (writer history + "EX masked this cycle" flag).
// Optional feature macro: HAZARD_PERF_EN (counters checked when defined).

module tb_hazard_forward_unit;

    localparam int REG_W = 5;
`ifdef HAZARD_PERF_EN
    localparam int CNT_W = 16;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [REG_W-1:0] RS1_ID = '0, RS2_ID = '0, RS1_EX = '0, RS2_EX = '0, RD_EX = '0;
    logic             RegWrite_EX = 1'b0, MemRead_EX = 1'b0, PCSrc_MEM = 1'b0;
    logic [1:0]       forwardA, forwardB;
    logic             PC_write, IF_ID_write, ID_EX_bubble;
    logic             IF_ID_flush, ID_EX_flush, EX_MEM_flush;
    logic [REG_W-1:0] RD_MEM_TAG, RD_WB_TAG;
`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;

    hazard_forward_unit #(.REG_W(REG_W)) dut (
        .clk(clk), .reset(reset),
        .RS1_ID(RS1_ID), .RS2_ID(RS2_ID),
        .RS1_EX(RS1_EX), .RS2_EX(RS2_EX), .RD_EX(RD_EX),
        .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .PCSrc_MEM(PCSrc_MEM),
        .forwardA(forwardA), .forwardB(forwardB),
        .PC_write(PC_write), .IF_ID_write(IF_ID_write), .ID_EX_bubble(ID_EX_bubble),
        .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush), .EX_MEM_flush(EX_MEM_flush),
        .RD_MEM_TAG(RD_MEM_TAG), .RD_WB_TAG(RD_WB_TAG)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Last two EX-stage instructions that really wrote a register (history),
    // and whether the current EX slot is a bubble/squashed (masked).
    bit       m_mem_v = 1'b0, m_wb_v = 1'b0, m_masked = 1'b0;
    bit [4:0] m_mem_rd = 5'd0, m_wb_rd = 5'd0;
    int       m_stall = 0, m_flush = 0;

    function automatic bit model_lu();
        return !reset && !m_masked && MemRead_EX && (RD_EX != 5'd0) &&
               ((RD_EX == RS1_ID) || (RD_EX == RS2_ID));
    endfunction

    function automatic int model_fwd(input bit [4:0] rs);
        if (reset || m_masked) return 0;
        if (m_mem_v && m_mem_rd == rs) return 2;
        if (m_wb_v && m_wb_rd == rs) return 1;
        return 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mem_v <= 1'b0; m_mem_rd <= 5'd0;
            m_wb_v  <= 1'b0; m_wb_rd  <= 5'd0;
            m_masked <= 1'b0;
            m_stall <= 0; m_flush <= 0;
        end else begin
            m_wb_v   <= m_mem_v;
            m_wb_rd  <= m_mem_rd;
            m_mem_v  <= RegWrite_EX && RD_EX != 5'd0 && !m_masked && !PCSrc_MEM;
            m_mem_rd <= RD_EX;
            m_masked <= PCSrc_MEM || model_lu();
            if (model_lu() && !PCSrc_MEM && m_stall < 65535) m_stall <= m_stall + 1;
            if (PCSrc_MEM && m_flush < 65535) m_flush <= m_flush + 1;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the clock edge.
    always @(negedge clk) begin
        chk("forwardA", int'(forwardA), model_fwd(RS1_EX));
        chk("forwardB", int'(forwardB), model_fwd(RS2_EX));
        chk("PC_write", int'(PC_write),
            (reset || PCSrc_MEM) ? 1 : (model_lu() ? 0 : 1));
        chk("IF_ID_write", int'(IF_ID_write),
            (reset || PCSrc_MEM) ? 1 : (model_lu() ? 0 : 1));
        chk("ID_EX_bubble", int'(ID_EX_bubble),
            (!reset && !PCSrc_MEM && model_lu()) ? 1 : 0);
        chk("IF_ID_flush", int'(IF_ID_flush), (!reset && PCSrc_MEM) ? 1 : 0);
        chk("ID_EX_flush", int'(ID_EX_flush), (!reset && PCSrc_MEM) ? 1 : 0);
        chk("EX_MEM_flush", int'(EX_MEM_flush), (!reset && PCSrc_MEM) ? 1 : 0);
        chk("RD_MEM_TAG", int'(RD_MEM_TAG), m_mem_v ? int'(m_mem_rd) : 0);
        chk("RD_WB_TAG", int'(RD_WB_TAG), m_wb_v ? int'(m_wb_rd) : 0);
`ifdef HAZARD_PERF_EN
        chk("stall_cnt", int'(stall_cnt), m_stall);
        chk("flush_cnt", int'(flush_cnt), m_flush);
`endif
    end

    // ---------------- stimulus ----------------
    // Apply one cycle of inputs just after the rising edge, return at the
    // following falling edge so the caller can check literal expectations.
    task automatic step(input logic rw, input logic mr, input logic pc,
                        input int rd, input int rs1e, input int rs2e,
                        input int rs1i, input int rs2i);
        @(posedge clk);
        #1;
        RegWrite_EX = rw;  MemRead_EX = mr;  PCSrc_MEM = pc;
        RD_EX  = REG_W'(rd);   RS1_EX = REG_W'(rs1e); RS2_EX = REG_W'(rs2e);
        RS1_ID = REG_W'(rs1i); RS2_ID = REG_W'(rs2i);
        @(negedge clk);
    endtask

    initial begin
        // Reset values.
        #1;
        chk("rst_PC_write", int'(PC_write), 1);
        chk("rst_forwardA", int'(forwardA), 0);
        chk("rst_RD_MEM_TAG", int'(RD_MEM_TAG), 0);
        chk("rst_ID_EX_bubble", int'(ID_EX_bubble), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // RAW distance 1.
        step(1, 0, 0, 5, 0, 0, 0, 0);
        step(0, 0, 0, 0, 5, 0, 0, 0);
        chk("raw1_forwardA", int'(forwardA), 2);
        chk("raw1_forwardB", int'(forwardB), 0);
        chk("raw1_RD_MEM_TAG", int'(RD_MEM_TAG), 5);

        // MEM over WB priority, then WB only.
        step(1, 0, 0, 7, 0, 0, 0, 0);
        step(1, 0, 0, 7, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 7, 0, 0);
        chk("prio_forwardB_mem", int'(forwardB), 2);
        step(1, 0, 0, 7, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 7, 0, 0);
        chk("prio_forwardB_wb", int'(forwardB), 1);

        // x0 is never forwarded.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("x0_forwardA", int'(forwardA), 0);
        chk("x0_RD_MEM_TAG", int'(RD_MEM_TAG), 0);

        // Load-use: one stall, stale EX contents masked, then WB forward.
        step(1, 1, 0, 3, 0, 0, 0, 3);
        chk("lu_PC_write", int'(PC_write), 0);
        chk("lu_IF_ID_write", int'(IF_ID_write), 0);
        chk("lu_ID_EX_bubble", int'(ID_EX_bubble), 1);
        step(1, 1, 0, 3, 0, 3, 0, 3);
        chk("stall_PC_write", int'(PC_write), 1);
        chk("stall_ID_EX_bubble", int'(ID_EX_bubble), 0);
        chk("stall_forwardB", int'(forwardB), 0);
        step(0, 0, 0, 0, 0, 3, 0, 0);
        chk("lu_consumer_forwardB", int'(forwardB), 1);

        // Flush beats stall, then FLUSH cycle masks EX.
        step(1, 1, 1, 4, 0, 0, 4, 0);
        chk("fbs_IF_ID_flush", int'(IF_ID_flush), 1);
        chk("fbs_ID_EX_flush", int'(ID_EX_flush), 1);
        chk("fbs_EX_MEM_flush", int'(EX_MEM_flush), 1);
        chk("fbs_PC_write", int'(PC_write), 1);
        chk("fbs_ID_EX_bubble", int'(ID_EX_bubble), 0);
        step(0, 0, 0, 0, 4, 4, 0, 0);
        chk("flush_forwardA", int'(forwardA), 0);
        chk("flush_forwardB", int'(forwardB), 0);
        chk("flush_RD_MEM_TAG", int'(RD_MEM_TAG), 0);

        // Reset asserted while in STALL acts without a clock edge.
        step(1, 1, 0, 6, 0, 0, 6, 0);
        chk("rs_lu_PC_write", int'(PC_write), 0);
        @(posedge clk);
        #1;
        chk("rs_stall_RD_MEM_TAG", int'(RD_MEM_TAG), 6);
        chk("rs_stall_PC_write", int'(PC_write), 1);
        #1 reset = 1'b1;
        #1;
        chk("rs_RD_MEM_TAG", int'(RD_MEM_TAG), 0);
        chk("rs_PC_write", int'(PC_write), 1);
        chk("rs_ID_EX_bubble", int'(ID_EX_bubble), 0);
`ifdef HAZARD_PERF_EN
        chk("rs_stall_cnt", int'(stall_cnt), 0);
`endif
        #1 reset = 1'b0;
        #1;
        chk("rs_back_in_run_PC_write", int'(PC_write), 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic on a narrow register range to provoke hits.
        for (int i = 0; i < 800; i++) begin
            @(posedge clk);
            #1;
            RegWrite_EX = ($urandom_range(0, 1) == 0);
            MemRead_EX  = ($urandom_range(0, 2) == 0);
            PCSrc_MEM   = ($urandom_range(0, 7) == 0);
            RD_EX  = REG_W'($urandom_range(0, 7));
            RS1_EX = REG_W'($urandom_range(0, 7));
            RS2_EX = REG_W'($urandom_range(0, 7));
            RS1_ID = REG_W'($urandom_range(0, 7));
            RS2_ID = REG_W'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
            end
        end
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

- Produces the forwarding selects, load-use stalls and branch flushes consumed by the EX stage and the IF/ID, ID/EX and EX/MEM pipeline registers of the 5-stage RISC-V core.
- Keeps its own registered shadow of the destination-register tags for the MEM and WB stages.
- Tracks stall/flush state in a 3-state FSM, so EX-stage operand selection is decided from registered tag state, not from downstream stage outputs.

## Interface
Parameters:
- REG_W, 5: register index width.
- CNT_W, 16: width of the performance counters (present only with HAZARD_PERF_EN).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `RS1_ID`, `RS2_ID` in REG_W: source indices of the instruction in ID.
- `RS1_EX`, `RS2_EX`, `RD_EX` in REG_W: indices of the instruction in EX.
- `RegWrite_EX`, `MemRead_EX` in 1: EX control bits.
- `PCSrc_MEM` in 1: taken branch resolved in MEM.
- `forwardA`, `forwardB` out 2: EX operand selects. 2'b00 = register file, 2'b01 = WB data (`ALU_DATA_WB`), 2'b10 = MEM ALU result (`ALU_OUT_MEM`); 2'b11 is never driven.
- `PC_write`, `IF_ID_write` out 1: update enables, 0 holds the register.
- `ID_EX_bubble` out 1: zero ID/EX control bits on next edge.
- `IF_ID_flush`, `ID_EX_flush`, `EX_MEM_flush` out 1: squash stage contents on next edge.
- `RD_MEM_TAG`, `RD_WB_TAG` out REG_W: shadow tags. Value is 0 when the tag is invalid.
- `stall_cnt`, `flush_cnt` out CNT_W: only with HAZARD_PERF_EN.

## Operation
- Shadow tags:
  - `mem_tag` = {valid, rd}, `wb_tag` = {valid, rd}.
  - Each edge: `wb_tag <= mem_tag`.
  - Each edge: `mem_tag <= {RegWrite_EX && RD_EX!=0 && state==RUN, RD_EX}`.
  - `mem_tag` valid is forced 0 when `PCSrc_MEM`=1.
  - A tag with rd=0 is never valid; x0 is never forwarded.
- EX inputs are masked (treated as a bubble) while state is STALL or FLUSH.
- Forwarding, combinational from the registered tags:
  - `forwardA` = 2'b10 if `mem_tag` is valid and its rd == `RS1_EX`.
  - Else 2'b01 if `wb_tag` is valid and its rd == `RS1_EX`.
  - Else 2'b00.
  - MEM has priority over WB. `forwardB` is identical using `RS2_EX`.
  - Both are 2'b00 while state is STALL or FLUSH.
- Load-use detect, `lu`: `MemRead_EX && RD_EX!=0 && (RD_EX==RS1_ID || RD_EX==RS2_ID) && state==RUN`.
- FSM states: RUN, STALL, FLUSH.
  - RUN: `PCSrc_MEM` -> FLUSH; else `lu` -> STALL; else stay in RUN.
  - STALL: lasts one cycle. `PCSrc_MEM` -> FLUSH, else -> RUN.
  - FLUSH: lasts one cycle. `PCSrc_MEM` -> FLUSH again, else -> RUN.
- Outputs, combinational in the current cycle:
  - When `PCSrc_MEM`=1: `IF_ID_flush`=`ID_EX_flush`=`EX_MEM_flush`=1, `PC_write`=1, `IF_ID_write`=1, `ID_EX_bubble`=0. Flush beats stall.
  - Else when `lu`=1: `PC_write`=0, `IF_ID_write`=0, `ID_EX_bubble`=1.
  - Otherwise: `PC_write`=`IF_ID_write`=1, all flush/bubble outputs 0.
- Reset values:
  - State RUN, both tags invalid (`RD_*_TAG`=0).
  - `forwardA`=`forwardB`=2'b00, `PC_write`=`IF_ID_write`=1.
  - All flush/bubble outputs 0; counters 0.

## Timing
- Forward selects are valid in the same cycle the consumer instruction is in EX. There is no added latency: the decision rests on tags registered on the previous edge.
- A load-use hazard costs exactly 1 stall cycle. The dependent instruction then reaches EX while the load is in WB, with select 2'b01.
- Back-to-back loads with a chained dependency stall once per pair. `lu` is suppressed in STALL because the EX bubble is masked.
- A taken branch costs 3 squashed slots. The FLUSH cycle masks stale EX inputs.
- Reset asserted mid-stall or mid-flush returns to RUN immediately and clears the tags; outputs take reset values asynchronously.
- `PCSrc_MEM` and `lu` in the same cycle: flush only; the stall is discarded.

## Configuration
- `HAZARD_PERF_EN` defined:
  - `stall_cnt` increments on every cycle with `lu`=1 and `PCSrc_MEM`=0.
  - `flush_cnt` increments on every cycle with `PCSrc_MEM`=1.
  - Both saturate at all-ones and clear on reset.
- Undefined: the counter ports and their logic are absent; all other behaviour is identical.

## Test plan
- RAW distance 1: `RD_EX`=5, `RegWrite_EX`=1, next cycle `RS1_EX`=5 -> `forwardA`=2'b10, `forwardB`=2'b00.
- MEM-over-WB priority: writes to x7 in two consecutive cycles, then `RS2_EX`=7 -> `forwardB`=2'b10. With one intervening non-writer instead -> 2'b01.
- x0: `RD_EX`=0, `RegWrite_EX`=1, then `RS1_EX`=0 -> `forwardA`=2'b00, `RD_MEM_TAG`=0.
- Load-use: `MemRead_EX`=1, `RD_EX`=3, `RS2_ID`=3 -> for one cycle `PC_write`=0, `IF_ID_write`=0, `ID_EX_bubble`=1; state STALL for one cycle; consumer then sees `forwardB`=2'b01.
- Flush beats stall: `lu` and `PCSrc_MEM` both 1 -> all three flushes=1, `PC_write`=1, `ID_EX_bubble`=0. Next cycle: state FLUSH, `forwardA`/`forwardB`=2'b00, `mem_tag` invalid.
- Reset asserted in STALL -> RUN, tags 0, `PC_write`=1 without waiting for a clock edge. With HAZARD_PERF_EN, `stall_cnt`=0.
